// File: rtl/fpu_addsub_post_norm.sv
`default_nettype none
// ============================================================================
// Module      : fpu_addsub_post_norm
// Description : Normalise/round stage following the FPU_32b add/sub mantissa
//               datapath. Takes an unnormalised sign/exponent/extended
//               mantissa sum, normalises it over several cycles (bounded left
//               shift per cycle), rounds per the captured mode and returns an
//               IEEE-754 single result plus status flags over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_addsub_post_norm #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk_i,
    input  logic        RST,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        sign_i,
    input  logic [8:0]  exp_i,
    input  logic [27:0] mant_i,
    input  logic [1:0]  mode_i,
    output logic [31:0] result,
    output logic        ine,
    output logic        overflow,
    output logic        underflow,
    output logic        inf,
    output logic        zero,
    output logic        out_valid_o,
    input  logic        out_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]  MODE_RNE  = 2'b00;
    localparam logic [1:0]  MODE_RTZ  = 2'b01;
    localparam logic [1:0]  MODE_RUP  = 2'b10;
    localparam logic [1:0]  MODE_RDN  = 2'b11;
    localparam logic [9:0]  STEP_W    = 10'(SHIFT_STEP);
    localparam logic [9:0]  EXP_MAX   = 10'd255;

    state_t      state_q,     state_d;
    logic        sign_q,      sign_d;
    logic [9:0]  exp_q,       exp_d;
    logic [27:0] mant_q,      mant_d;
    logic [1:0]  mode_q,      mode_d;
    logic [31:0] result_q,    result_d;
    logic        ine_q,       ine_d;
    logic        overflow_q,  overflow_d;
    logic        underflow_q, underflow_d;
    logic        inf_q,       inf_d;
    logic        zero_q,      zero_d;
    logic        out_valid_q, out_valid_d;

    // Rounding datapath results, consumed only in ROUND
    logic        rnd_inexact;
    logic        rnd_inc;
    logic [24:0] rnd_sum;
    logic [23:0] rnd_mant;
    logic [9:0]  rnd_exp;
    logic [7:0]  rnd_exp_field;
    logic        rnd_inf_sel;
    logic [31:0] rnd_result;
    logic        rnd_ine;
    logic        rnd_overflow;
    logic        rnd_underflow;
    logic        rnd_inf;
    logic        rnd_zero;

    // Normalisation shift amount
    logic [4:0]  lz;
    logic [9:0]  lz_w;
    logic [9:0]  exp_room;
    logic [9:0]  shift_amt;

    // Count of zero bits from the hidden position downward to the first one
    function automatic logic [4:0] lead_zeros(input logic [26:0] m);
        logic [4:0] n;
        logic       hit;
        n   = 5'd0;
        hit = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!hit) begin
                if (m[i]) hit = 1'b1;
                else      n   = n + 5'd1;
            end
        end
        return n;
    endfunction

    // Left-shift distance: limited by leading zeros, per-cycle step and
    // the exponent floor of 1 (so denormals stop shifting at exp==1)
    always_comb begin
        lz        = lead_zeros(mant_q[26:0]);
        lz_w      = {5'd0, lz};
        exp_room  = exp_q - 10'd1;
        shift_amt = lz_w;
        if (STEP_W < shift_amt)   shift_amt = STEP_W;
        if (exp_room < shift_amt) shift_amt = exp_room;
    end

    // Round the normalised value and form the packed result and flags
    always_comb begin
        rnd_inexact = |mant_q[2:0];
        rnd_inc     = 1'b0;
        case (mode_q)
            MODE_RNE: rnd_inc = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
            MODE_RTZ: rnd_inc = 1'b0;
            MODE_RUP: rnd_inc = ~sign_q & rnd_inexact;
            MODE_RDN: rnd_inc = sign_q & rnd_inexact;
            default:  rnd_inc = 1'b0;
        endcase

        rnd_sum = {1'b0, mant_q[26:3]} + {24'd0, rnd_inc};
        if (rnd_sum[24]) begin
            // 1.111..1 + ulp wraps to 10.0: renormalise to 1.0
            rnd_mant = 24'h800000;
            rnd_exp  = exp_q + 10'd1;
        end else begin
            rnd_mant = rnd_sum[23:0];
            rnd_exp  = exp_q;
        end

        // exp==1 without a hidden one is a denormal, encoded with field 0
        if ((rnd_exp == 10'd1) && !rnd_mant[23]) rnd_exp_field = 8'd0;
        else                                     rnd_exp_field = rnd_exp[7:0];

        rnd_inf_sel = (mode_q == MODE_RNE)
                    | ((mode_q == MODE_RUP) & ~sign_q)
                    | ((mode_q == MODE_RDN) &  sign_q);

        rnd_result    = {sign_q, rnd_exp_field, rnd_mant[22:0]};
        rnd_ine       = rnd_inexact;
        rnd_overflow  = 1'b0;
        rnd_underflow = 1'b0;
        rnd_inf       = 1'b0;
        rnd_zero      = 1'b0;

        if (mant_q == 28'd0) begin
            // Exact cancellation: sign is + except when rounding toward -inf
            rnd_result = (mode_q == MODE_RDN) ? 32'h8000_0000 : 32'h0000_0000;
            rnd_ine    = 1'b0;
            rnd_zero   = 1'b1;
        end else if (rnd_exp >= EXP_MAX) begin
            rnd_overflow = 1'b1;
            rnd_ine      = 1'b1;
            if (rnd_inf_sel) begin
                rnd_result = {sign_q, 8'hFF, 23'd0};
                rnd_inf    = 1'b1;
            end else begin
                rnd_result = {sign_q, 31'h7F7F_FFFF};
            end
        end else begin
            rnd_underflow = (rnd_exp_field == 8'd0) & rnd_inexact;
        end
    end

    // Next-state and datapath update for the IDLE/NORM/ROUND/DONE sequence
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        mode_d      = mode_q;
        result_d    = result_q;
        ine_d       = ine_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        inf_d       = inf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    sign_d  = sign_i;
                    exp_d   = {1'b0, exp_i};
                    mant_d  = mant_i;
                    mode_d  = mode_i;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (mant_q[27]) begin
                    // Carry out: one right shift, dropped bit folds into sticky
                    mant_d  = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_q + 10'd1;
                    state_d = S_ROUND;
                end else if (mant_q == 28'd0) begin
                    state_d = S_ROUND;
                end else if (mant_q[26] || (exp_q <= 10'd1)) begin
                    state_d = S_ROUND;
                end else begin
                    mant_d = mant_q << shift_amt;
                    exp_d  = exp_q - shift_amt;
                end
            end
            S_ROUND: begin
                result_d    = rnd_result;
                ine_d       = rnd_ine;
                overflow_d  = rnd_overflow;
                underflow_d = rnd_underflow;
                inf_d       = rnd_inf;
                zero_d      = rnd_zero;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= 10'd0;
            mant_q      <= 28'd0;
            mode_q      <= 2'd0;
            result_q    <= 32'd0;
            ine_q       <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            mode_q      <= mode_d;
            result_q    <= result_d;
            ine_q       <= ine_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            inf_q       <= inf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign result      = result_q;
    assign ine         = ine_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign inf         = inf_q;
    assign zero        = zero_q;
    assign out_valid_o = out_valid_q;

endmodule
`default_nettype wire

// File: doc/fpu_addsub_post_norm.md
Name: fpu_addsub_post_norm

Overview:
- Normalisation/rounding stage that sits directly downstream of the FPU_32b add/sub mantissa datapath.
- Consumes an unnormalised sign/exponent/extended-mantissa sum.
- Normalises it with a multi-cycle left/right shift FSM and rounds per mode_i.
- Emits the IEEE-754 single result plus ine/overflow/underflow/inf/zero flags over a valid/ready handshake.

Parameters:
SHIFT_STEP, 4, maximum left-shift positions applied per NORM cycle (1..26)

Ports:
clk_i  input  1  clock, all state on rising edge
RST  input  1  synchronous, active-low reset
in_valid_i  input  1  upstream sum valid
in_ready_o  output  1  stage can accept (high only in IDLE)
sign_i  input  1  result sign
exp_i  input  9  biased exponent of the larger operand; denormal operands presented as 1
mant_i  input  28  [27]=carry, [26]=hidden position, [25:3]=fraction, [2]=guard, [1]=round, [0]=sticky
mode_i  input  2  rounding: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
result  output  32  packed single result
ine  output  1  inexact
overflow  output  1  rounded exponent >= 255
underflow  output  1  result tiny (exp field 0) and inexact
inf  output  1  result is +/-infinity
zero  output  1  result magnitude is zero
out_valid_o  output  1  result/flags valid
out_ready_i  input  1  downstream accepts

Behaviour:
- Reset (RST=0 at a clock edge): state=IDLE; result=0, all flags 0, out_valid_o=0, in_ready_o=1. Reset applies in any state; an in-flight operation is discarded.
- IDLE: in_ready_o=1. On in_valid_i=1, capture sign_i/exp_i/mant_i/mode_i and go to NORM. mode_i is sampled only at accept.
- NORM, evaluated one case per cycle:
  - mant[27]=1: shift right 1, OR the shifted-out bit into sticky, exp+1, go to ROUND.
  - mant==0: go to ROUND (exact zero).
  - mant[26]=1 or exp==1: go to ROUND.
  - Otherwise: shift left by s=min(leading zeros above bit 26, SHIFT_STEP, exp-1); exp-=s; stay in NORM.
- ROUND:
  - g,r,st = mant[2:0]; ine = |{g,r,st}.
  - Increment when:
    - nearest: g & (r|st|mant[3]).
    - toward zero: never.
    - +inf: ~sign & ine.
    - -inf: sign & ine.
  - Add the increment to mant[26:3]. If that carries out, the mantissa becomes 1.0 and exp+1.
  - Exp field = 0 when exp==1 and hidden bit is 0 (denormal); otherwise exp.
  - If the final exp >= 255: overflow=1, ine=1.
    - Result is inf when (nearest) or (+inf mode & ~sign) or (-inf mode & sign), and then inf=1.
    - Otherwise result is max finite 0x7F7FFFFF with the sign applied.
  - Exact zero: result=0x00000000, or 0x80000000 in mode 11; zero=1, other flags 0.
  - underflow = (exp field 0) & ine.
  - Register result/flags, set out_valid_o=1, go to DONE.
- DONE: outputs held stable while out_ready_i=0. On out_ready_i=1, clear out_valid_o and go to IDLE. No new accept in the same cycle (in_ready_o=0 in DONE).
- Latency, accept edge to out_valid_o high:
  - 3 cycles when no left shift is needed.
  - Plus ceil(lz/SHIFT_STEP) cycles otherwise.
  - Worst case 3+ceil(26/SHIFT_STEP).
- Widths: internal exponent is 10 bits unsigned to hold 255+1 without wrap. Left shifts never drive exp below 1.
- Flags change only when out_valid_o rises. They hold their value until the next result.

Test Plan:
- 1.0+1.0: sign 0, exp 127, mant 28'h8000000, mode 00 -> result 0x40000000, all flags 0, out_valid_o 3 cycles after accept.
- 10.5-10.0: exp 130, mant 28'h0400000, SHIFT_STEP=4 -> one NORM shift cycle, result 0x3F000000, latency 4. Repeat with SHIFT_STEP=1 -> latency 7, same result.
- x-x: mant 0, mode 00 -> 0x00000000, zero=1; mode 11 -> 0x80000000, zero=1.
- Round carry: exp 127, mant 28'h7FFFFFC, mode 00 -> 0x40000000, ine=1. Same input with mode 01 -> 0x3FFFFFFF, ine=1.
- Overflow: exp 254, mant 28'h8000000 -> mode 00 gives 0x7F800000 with overflow=inf=ine=1. Mode 01 gives 0x7F7FFFFF with inf=0. Sign 1 with mode 10 gives 0xFF7FFFFF.
- Handshake/reset:
  - Hold out_ready_i=0 for 10 cycles: result stable, in_ready_o=0, second in_valid_i ignored.
  - Then assert out_ready_i: IDLE on the next cycle.
  - Assert RST=0 during NORM: next cycle out_valid_o=0, in_ready_o=1, result=0.
